// File: rtl/shift_arbiter.sv
// Two-requester front end for one shared 32-bit left shifter with a one-entry tagged result buffer.
// Define SHIFT_ARB_RR_EN for round-robin arbitration; otherwise requester 0 has fixed priority.
module shift_arbiter (
  input  logic        clock,
  input  logic        reset_n,
  input  logic        req0_valid,
  input  logic [31:0] req0_data,
  input  logic [4:0]  req0_amt,
  output logic        req0_ready,
  input  logic        req1_valid,
  input  logic [31:0] req1_data,
  input  logic [4:0]  req1_amt,
  output logic        req1_ready,
  output logic        resp_valid,
  output logic [31:0] resp_data,
  output logic        resp_id,
  input  logic        resp_ready,
  output logic [15:0] xfer_count
);

  typedef enum logic {EMPTY = 1'b0, FULL = 1'b1} state_t;

  state_t      state, state_nxt;
  logic        grant0, grant1;
  logic        can_accept, accept, drain, sel;
  logic [31:0] operand, shifted;
  logic [4:0]  amt;

`ifdef SHIFT_ARB_RR_EN
  // last = ID of the most recent accept; a tie goes to the other requester.
  logic last;

  always_comb begin
    grant0 = req0_valid & (~req1_valid | last);
    grant1 = req1_valid & (~req0_valid | ~last);
  end

  always_ff @(posedge clock) begin
    if (!reset_n)    last <= 1'b1;
    else if (accept) last <= sel;
  end
`else
  always_comb begin
    grant0 = req0_valid;
    grant1 = req1_valid & ~req0_valid;
  end
`endif

  // Reset blocks acceptance so nothing looks transferred on a reset edge.
  assign can_accept = reset_n & ((state == EMPTY) | resp_ready);
  assign req0_ready = grant0 & can_accept;
  assign req1_ready = grant1 & can_accept;
  assign accept     = req0_ready | req1_ready;
  assign sel        = req1_ready;
  assign drain      = (state == FULL) & resp_ready;

  assign operand = sel ? req1_data : req0_data;
  assign amt     = sel ? req1_amt  : req0_amt;
  assign shifted = operand << amt;

  always_ff @(posedge clock) begin
    if (!reset_n) state <= EMPTY;
    else          state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    if (accept)     state_nxt = FULL;
    else if (drain) state_nxt = EMPTY;
  end

  always_comb begin
    resp_valid = (state == FULL);
  end

  always_ff @(posedge clock) begin
    if (!reset_n) begin
      resp_data <= 32'h0;
      resp_id   <= 1'b0;
    end else if (accept) begin
      resp_data <= shifted;
      resp_id   <= sel;
    end
  end

  always_ff @(posedge clock) begin
    if (!reset_n)   xfer_count <= 16'h0;
    else if (drain) xfer_count <= xfer_count + 16'h1;
  end

endmodule

// File: tb/tb_shift_arbiter.sv
// Directed bench for shift_arbiter: stimulus pushes hand-computed results, a monitor pops them on each drain.
module tb_shift_arbiter;

  logic        clock = 1'b0;
  logic        reset_n;
  logic        req0_valid, req1_valid, req0_ready, req1_ready;
  logic [31:0] req0_data, req1_data, resp_data;
  logic [4:0]  req0_amt, req1_amt;
  logic        resp_valid, resp_id, resp_ready;
  logic [15:0] xfer_count;

  typedef struct packed {logic id; logic [31:0] data;} exp_t;
  exp_t        q[$];
  int          tests = 0, fails = 0, ndrain = 0, start = 0;
  logic [15:0] exp_cnt = 16'h0;

  shift_arbiter dut (
    .clock(clock), .reset_n(reset_n),
    .req0_valid(req0_valid), .req0_data(req0_data), .req0_amt(req0_amt), .req0_ready(req0_ready),
    .req1_valid(req1_valid), .req1_data(req1_data), .req1_amt(req1_amt), .req1_ready(req1_ready),
    .resp_valid(resp_valid), .resp_data(resp_data), .resp_id(resp_id), .resp_ready(resp_ready),
    .xfer_count(xfer_count)
  );

  always #5 clock = ~clock;

  task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      if (fails <= 20) $display("FAIL %s got=%h expected=%h t=%0t", nm, got, exp, $time);
    end
  endtask

  task automatic drive(input logic v0, input logic [31:0] d0, input logic [4:0] a0,
                       input logic v1, input logic [31:0] d1, input logic [4:0] a1, input logic rr);
    req0_valid = v0; req0_data = d0; req0_amt = a0;
    req1_valid = v1; req1_data = d1; req1_amt = a1;
    resp_ready = rr;
  endtask

  // One cycle: drive, check grants mid-cycle, record the expected result of an accept.
  task automatic cyc(input logic v0, input logic [31:0] d0, input logic [4:0] a0,
                     input logic v1, input logic [31:0] d1, input logic [4:0] a1, input logic rr,
                     input logic e0, input logic e1, input logic [31:0] ed, input logic eid,
                     input string nm);
    drive(v0, d0, a0, v1, d1, a1, rr);
    @(negedge clock);
    chk({nm, " req0_ready"}, {31'b0, req0_ready}, {31'b0, e0});
    chk({nm, " req1_ready"}, {31'b0, req1_ready}, {31'b0, e1});
    if (e0 | e1) q.push_back(exp_t'{id: eid, data: ed});
    @(posedge clock); #1;
  endtask

  task automatic idle();
    cyc(1'b0, 32'h0, 5'd0, 1'b0, 32'h0, 5'd0, 1'b1, 1'b0, 1'b0, 32'h0, 1'b0, "idle");
  endtask

  // Monitor: a drain happens on the next edge whenever valid & ready are seen here.
  always @(negedge clock) begin
    if (!reset_n) begin
      exp_cnt = 16'h0;
    end else begin
      chk("xfer_count", {16'h0, xfer_count}, {16'h0, exp_cnt});
      if (resp_valid && resp_ready) begin
        if (q.size() == 0) begin
          tests++; fails++;
          if (fails <= 20) $display("FAIL unexpected_result got=%h/%0d expected=none", resp_data, resp_id);
        end else begin
          exp_t e;
          e = q.pop_front();
          chk("resp_data", resp_data, e.data);
          chk("resp_id", {31'b0, resp_id}, {31'b0, e.id});
        end
        exp_cnt = exp_cnt + 16'h1;
        ndrain++;
      end
    end
  end

  initial begin
    reset_n = 1'b0;
    drive(1'b1, 32'hFFFF_FFFF, 5'd1, 1'b1, 32'hFFFF_FFFF, 5'd1, 1'b1);
    repeat (2) begin
      @(negedge clock);
      chk("rst req0_ready", {31'b0, req0_ready}, 32'h0);
      chk("rst req1_ready", {31'b0, req1_ready}, 32'h0);
    end
    @(posedge clock); #1;
    chk("rst resp_valid", {31'b0, resp_valid}, 32'h0);
    chk("rst resp_data", resp_data, 32'h0);
    chk("rst resp_id", {31'b0, resp_id}, 32'h0);
    chk("rst xfer_count", {16'h0, xfer_count}, 32'h0);
    drive(1'b0, 32'h0, 5'd0, 1'b0, 32'h0, 5'd0, 1'b1);
    reset_n = 1'b1;

    // single request and latency
    cyc(1, 32'h0000_00F1, 5'd4, 0, 32'h0, 5'd0, 1, 1, 0, 32'h0000_0F10, 0, "single");
    chk("single resp_valid", {31'b0, resp_valid}, 32'h1);
    chk("single resp_data", resp_data, 32'h0000_0F10);
    idle();
    chk("single xfer_count", {16'h0, xfer_count}, 32'h1);

    // shift amount boundaries; final accept leaves the pointer at requester 1
    cyc(0, 32'h0, 5'd0, 1, 32'hDEAD_BEEF, 5'd0, 1, 0, 1, 32'hDEAD_BEEF, 1, "amt0");
    cyc(1, 32'h0000_0003, 5'd31, 0, 32'h0, 5'd0, 1, 1, 0, 32'h8000_0000, 0, "amt31");
    cyc(0, 32'h0, 5'd0, 1, 32'hFFFF_FFFF, 5'd16, 1, 0, 1, 32'hFFFF_0000, 1, "amt16");
    idle();

    // contention: both valid every cycle
    for (int i = 0; i < 4; i++) begin
`ifdef SHIFT_ARB_RR_EN
      if (i % 2 == 0)
        cyc(1, 32'h1, 5'd1, 1, 32'h1, 5'd2, 1, 1, 0, 32'h2, 0, "contend");
      else
        cyc(1, 32'h1, 5'd1, 1, 32'h1, 5'd2, 1, 0, 1, 32'h4, 1, "contend");
`else
      cyc(1, 32'h1, 5'd1, 1, 32'h1, 5'd2, 1, 1, 0, 32'h2, 0, "contend");
`endif
    end
    idle();

    // backpressure, then drain and refill on the same edge
    cyc(1, 32'h0000_00A5, 5'd8, 0, 32'h0, 5'd0, 1, 1, 0, 32'h0000_A500, 0, "bp load");
    repeat (3) begin
      cyc(1, 32'h1, 5'd3, 1, 32'h1, 5'd3, 0, 0, 0, 32'h0, 0, "bp hold");
      chk("bp resp_valid", {31'b0, resp_valid}, 32'h1);
      chk("bp resp_data", resp_data, 32'h0000_A500);
      chk("bp resp_id", {31'b0, resp_id}, 32'h0);
    end
    cyc(0, 32'h0, 5'd0, 1, 32'h7, 5'd4, 1, 0, 1, 32'h70, 1, "bp release");
    chk("release resp_data", resp_data, 32'h70);
    chk("release resp_id", {31'b0, resp_id}, 32'h1);
    idle();

    // mid-stream reset discards a buffered result and clears the counter
    cyc(1, 32'h5, 5'd1, 0, 32'h0, 5'd0, 0, 1, 0, 32'hA, 0, "pre rst");
    reset_n = 1'b0;
    drive(1, 32'h1, 5'd1, 1, 32'h1, 5'd1, 1);
    @(negedge clock);
    chk("midrst req0_ready", {31'b0, req0_ready}, 32'h0);
    chk("midrst req1_ready", {31'b0, req1_ready}, 32'h0);
    @(posedge clock); #1;
    q.delete();
    drive(1'b0, 32'h0, 5'd0, 1'b0, 32'h0, 5'd0, 1'b1);
    reset_n = 1'b1;
    chk("midrst resp_valid", {31'b0, resp_valid}, 32'h0);
    chk("midrst resp_data", resp_data, 32'h0);
    chk("midrst xfer_count", {16'h0, xfer_count}, 32'h0);

    // counter wrap: 65536 back-to-back drains
    drive(1'b1, 32'h1, 5'd0, 1'b0, 32'h0, 5'd0, 1'b1);
    start = ndrain;
    for (int i = 0; i < 70000 && (ndrain - start) < 65536; i++) begin
      @(negedge clock);
      q.push_back(exp_t'{id: 1'b0, data: 32'h1});
      @(posedge clock); #2;
    end
    chk("wrap drains", ndrain - start, 65536);
    chk("wrap xfer_count", {16'h0, xfer_count}, 32'h0);
    drive(1'b0, 32'h0, 5'd0, 1'b0, 32'h0, 5'd0, 1'b1);
    idle();
    idle();
    chk("queue empty", q.size(), 0);
    chk("post wrap xfer_count", {16'h0, xfer_count}, 32'h1);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
